// File: rtl/gcd_pkg.sv
// Shared encodings and default widths for the subtractive GCD sequencer.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH  = 8;
  localparam int unsigned GCD_ITER_W = 9;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SUB_A = 3'd2,
    SUB_B = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/gcd_sequencer_if.sv
// Host handshake plus external-ALU wiring for the GCD sequencer.
interface gcd_sequencer_if
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH  = GCD_WIDTH,
  parameter int unsigned ITER_W = GCD_ITER_W
);

  logic              start;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic [WIDTH-1:0]  alu_out;
  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_b;
  logic              alu_s;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic [ITER_W-1:0] iter_count;

  modport slave (
    input  start, in_a, in_b, alu_out,
    output alu_a, alu_b, alu_s, busy, done, result, iter_count
  );

  modport master (
    output start, in_a, in_b, alu_out,
    input  alu_a, alu_b, alu_s, busy, done, result, iter_count
  );

endinterface

// File: rtl/gcd_sequencer.sv
// Subtractive GCD controller: steers an external add/sub ALU and captures its
// result back into the operand registers until the operands meet.
module gcd_sequencer
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH  = GCD_WIDTH,
  parameter int unsigned ITER_W = GCD_ITER_W
) (
  input  logic           clk,
  input  logic           reset,
  gcd_sequencer_if.slave bus
);

  localparam logic [ITER_W-1:0] ITER_MAX = '1;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  ra, ra_nx;
  logic [WIDTH-1:0]  rb, rb_nx;
  logic [WIDTH-1:0]  result_q, result_nx;
  logic [ITER_W-1:0] iter_q, iter_nx, iter_inc;

  logic [WIDTH-1:0]  alu_a_c;
  logic [WIDTH-1:0]  alu_b_c;
  logic              alu_s_c;
  logic              busy_c;
  logic              done_c;

  // Saturating increment so a long job never wraps the counter.
  assign iter_inc = (iter_q == ITER_MAX) ? iter_q : iter_q + ITER_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ra       <= '0;
      rb       <= '0;
      result_q <= '0;
      iter_q   <= '0;
    end else begin
      state    <= state_nx;
      ra       <= ra_nx;
      rb       <= rb_nx;
      result_q <= result_nx;
      iter_q   <= iter_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    ra_nx     = ra;
    rb_nx     = rb;
    result_nx = result_q;
    iter_nx   = iter_q;
    alu_a_c   = '0;
    alu_b_c   = '0;
    alu_s_c   = ALU_ADD;
    busy_c    = (state != IDLE);
    done_c    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          ra_nx    = bus.in_a;
          rb_nx    = bus.in_b;
          iter_nx  = '0;
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if (ra == '0) begin
          result_nx = rb;
          state_nx  = DONE;
        end else if (rb == '0) begin
          result_nx = ra;
          state_nx  = DONE;
        end else if (ra == rb) begin
          result_nx = ra;
          state_nx  = DONE;
        end else if (ra > rb) begin
          state_nx = SUB_A;
        end else begin
          state_nx = SUB_B;
        end
      end
      // Larger operand is always the minuend, so the ALU never wraps.
      SUB_A: begin
        alu_a_c  = ra;
        alu_b_c  = rb;
        alu_s_c  = ALU_SUB;
        ra_nx    = bus.alu_out;
        iter_nx  = iter_inc;
        state_nx = CHECK;
      end
      SUB_B: begin
        alu_a_c  = rb;
        alu_b_c  = ra;
        alu_s_c  = ALU_SUB;
        rb_nx    = bus.alu_out;
        iter_nx  = iter_inc;
        state_nx = CHECK;
      end
      DONE: begin
        done_c   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.alu_a      = alu_a_c;
  assign bus.alu_b      = alu_b_c;
  assign bus.alu_s      = alu_s_c;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.result     = result_q;
  assign bus.iter_count = iter_q;

endmodule

// File: tb/tb_gcd_sequencer.sv
// Bench for gcd_sequencer with a behavioural add/sub ALU and a result scoreboard.
module tb_gcd_sequencer;

  logic clk = 1'b0;
  logic reset;

  gcd_sequencer_if bus ();

  gcd_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.alu_out = bus.alu_s ? (bus.alu_a - bus.alu_b) : (bus.alu_a + bus.alu_b);

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    int         iter;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    int         iter;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Called at a negedge; drives one job and follows it through done.
  task automatic run_job(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input int iter, input int inject_k);
    exp_t e;
    int   k;
    int   subs;
    bit   seen;
    bit   busy_drop;
    bus.start = 1'b1;
    bus.in_a  = a;
    bus.in_b  = b;
    @(posedge clk);
    e.res  = res;
    e.iter = iter;
    sb.push_back(e);
    #1;
    bus.start = 1'b0;
    bus.in_a  = 8'($urandom);
    bus.in_b  = 8'($urandom);
    k = 0; subs = 0; seen = 1'b0; busy_drop = 1'b0;
    while (!seen && k < 600) begin
      @(negedge clk);
      k++;
      if (inject_k == k) begin
        bus.start = 1'b1;
        bus.in_a  = 8'd7;
        bus.in_b  = 8'd3;
      end else if (inject_k == k - 1) begin
        bus.start = 1'b0;
      end
      if (!bus.busy) busy_drop = 1'b1;
      if (bus.alu_s) begin
        subs++;
        check("alu_order", int'(bus.alu_a >= bus.alu_b), 1);
      end
      if (bus.done) begin
        seen = 1'b1;
        e = sb.pop_front();
        check("result", int'(bus.result), int'(e.res));
        check("iter_count", int'(bus.iter_count), e.iter);
        check("latency", k, 2 + 2 * e.iter);
        check("sub_cycles", subs, e.iter);
      end
    end
    bus.start = 1'b0;
    if (!seen) begin
      check("done_timeout", 0, 1);
      void'(sb.pop_front());
    end
    check("busy_during_job", int'(busy_drop), 0);
    @(negedge clk);
    check("done_single_pulse", int'(bus.done), 0);
    check("busy_idle", int'(bus.busy), 0);
    check("result_held", int'(bus.result), int'(res));
  endtask

  initial begin
    int done_seen;
    vecs[0] = '{8'd12,  8'd8,  8'd4,  2};
    vecs[1] = '{8'd0,   8'd35, 8'd35, 0};
    vecs[2] = '{8'd35,  8'd0,  8'd35, 0};
    vecs[3] = '{8'd0,   8'd0,  8'd0,  0};
    vecs[4] = '{8'd21,  8'd21, 8'd21, 0};
    vecs[5] = '{8'd17,  8'd5,  8'd1,  6};
    vecs[6] = '{8'd100, 8'd75, 8'd25, 3};
    vecs[7] = '{8'd255, 8'd1,  8'd1,  254};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.in_a  = '0;
    bus.in_b  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_result", int'(bus.result), 0);
    check("rst_iter", int'(bus.iter_count), 0);
    check("rst_alu_s", int'(bus.alu_s), 0);
    check("rst_alu_a", int'(bus.alu_a), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_job(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].iter, 0);

    // Start pulsed mid-job must be ignored; next job follows straight after done.
    run_job(8'd48, 8'd18, 8'd6, 4, 3);
    run_job(8'd7,  8'd3,  8'd1, 4, 0);

    // Reset three cycles into a job aborts it with no done pulse.
    bus.start = 1'b1;
    bus.in_a  = 8'd48;
    bus.in_b  = 8'd18;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_busy", int'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_result", int'(bus.result), 0);
    check("abort_iter", int'(bus.iter_count), 0);
    check("abort_alu_s", int'(bus.alu_s), 0);
    reset = 1'b0;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gcd_sequencer.md
Name: gcd_sequencer

Overview:
- Multi-cycle controller plus operand registers that compute GCD(in_a, in_b) by repeated subtraction.
- Sits directly upstream of the 8-bit add/subtract ALU. It drives the ALU operands and add/sub select, and captures the ALU result back into its own registers.
- Exposes a start/busy/done handshake toward the host logic.
- The ALU is external: the parent instantiates it and wires alu_a/alu_b/alu_s/alu_out.

Parameters:
- WIDTH, 8: datapath width of the operands, result and ALU interface.
- ITER_W, 9: width of the subtraction-iteration counter; must hold 2^WIDTH-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- start  input  1  request; accepted only in IDLE.
- in_a  input  WIDTH  operand A; sampled on the accepting edge.
- in_b  input  WIDTH  operand B; sampled on the accepting edge.
- alu_out  input  WIDTH  combinational ALU result.
- alu_a  output  WIDTH  ALU operand a (minuend).
- alu_b  output  WIDTH  ALU operand b (subtrahend).
- alu_s  output  1  ALU select: 1 = subtract, 0 = add.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle pulse when the result is valid.
- result  output  WIDTH  GCD; held from DONE until the next accepted start.
- iter_count  output  ITER_W  number of subtractions performed in the current/last job.

Behaviour:
- One clock domain, synchronous active-high reset.
- On reset: state=IDLE, ra=rb=0, result=0, done=0, iter_count=0. Reset mid-job aborts immediately with no done pulse.
- States and transitions:
  - IDLE: if start=1, ra<=in_a, rb<=in_b, iter_count<=0, go CHECK. Otherwise stay.
  - CHECK, priority order:
    - ra==0: result<=rb, go DONE.
    - else rb==0: result<=ra, go DONE.
    - else ra==rb: result<=ra, go DONE.
    - else ra>rb (unsigned): go SUB_A.
    - else: go SUB_B.
  - SUB_A: alu_a=ra, alu_b=rb, alu_s=1; ra<=alu_out; iter_count+1; go CHECK.
  - SUB_B: alu_a=rb, alu_b=ra, alu_s=1; rb<=alu_out; iter_count+1; go CHECK.
  - DONE: done=1 for this cycle only; go IDLE.
- Outside SUB_A/SUB_B, alu_a=0, alu_b=0, alu_s=0. The ALU is never asked to subtract a larger value from a smaller one, so no wrap-around ever occurs.
- alu_a/alu_b/alu_s/busy/done decode from the registered state: Moore outputs, no combinational path from start.
- Latency:
  - start edge -> CHECK next cycle.
  - Each subtraction costs 2 cycles (SUB + CHECK).
  - done is asserted (2 + 2*iter_count) cycles after the accepting edge.
  - Worst case at WIDTH=8 is GCD(255,1): 254 subtractions.
- start while busy (any non-IDLE state, including DONE) is ignored; in_a/in_b changes after acceptance have no effect.
- start high in the cycle after DONE (back in IDLE) is accepted normally.
- GCD(0,0)=0, GCD(0,x)=x, GCD(x,0)=x, each with iter_count=0 and done 2 cycles after start.
- iter_count saturates at all-ones; it never wraps.

Decomposition:
- Shared package gcd_pkg holds:
  - state encoding constants: IDLE, CHECK, SUB_A, SUB_B, DONE (3-bit);
  - default WIDTH/ITER_W constants;
  - ALU select constants ALU_ADD=0, ALU_SUB=1.
- Single module with no sub-module: next-state/output decode plus ra/rb/result/counter registers.
- A thin top (gcd_top) in the parent instantiates gcd_sequencer and the existing alu.

Test Plan:
- Reset mid-job: reset, then start with in_a=48, in_b=18; assert reset at cycle 3 -> next cycle busy=0, done=0, result=0, iter_count=0, alu_s=0; no done pulse follows.
- Basic run with ALU wired: in_a=12, in_b=8 -> SUB_A (12-8), SUB_B (8-4); done pulses exactly 6 cycles after the accepting edge; result=4, iter_count=2; busy high for cycles 1-6.
- Zero and equal operands:
  - in_a=0, in_b=35 -> result=35.
  - in_a=35, in_b=0 -> result=35.
  - in_a=0, in_b=0 -> result=0.
  - in_a=21, in_b=21 -> result=21.
  - Each case: iter_count=0, done at cycle 2.
- Worst case: in_a=255, in_b=1 -> result=1, iter_count=254, done at cycle 510. Check every SUB cycle has alu_s=1 and alu_a>=alu_b.
- Busy protection and back-to-back:
  - Mid-job (in_a=48, in_b=18, result 6), pulse start with in_a=7, in_b=3 -> ignored; result=6.
  - Then start in the cycle after done with in_a=7, in_b=3 -> result=1, iter_count=4.
